// File: rtl/bt_clk_pkg.sv
// Shared definitions for the Bluetooth slave clock tracking path.
//   trk_state_e     : tracker state (IDLE, ACQUIRE, TRACK, LOST)
//   SLOT_US         : slot length in microseconds
//   HALF_SLOT_US    : largest phase error magnitude / largest normal window
//   WIN_OPEN_ALWAYS : window size that holds the clock block window open
//   slot_err()      : wrapped phase error of a sync against its expected position
package bt_clk_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2,
        LOST    = 2'd3
    } trk_state_e;

    localparam logic [9:0] SLOT_US         = 10'd625;
    localparam logic [8:0] HALF_SLOT_US    = 9'd312;
    localparam logic [8:0] WIN_OPEN_ALWAYS = 9'd313;

    // Difference wrapped into the nearest half slot so a sync just before the
    // slot boundary reads as early rather than almost a whole slot late.
    function automatic logic signed [9:0] slot_err(input logic [9:0] cnt,
                                                   input logic [9:0] pos);
        logic signed [10:0] raw;
        logic signed [10:0] fixed;
        raw = $signed({1'b0, cnt}) - $signed({1'b0, pos});
        if (raw > $signed({2'b00, HALF_SLOT_US})) begin
            fixed = raw - $signed({1'b0, SLOT_US});
        end else if (raw < -$signed({2'b00, HALF_SLOT_US})) begin
            fixed = raw + $signed({1'b0, SLOT_US});
        end else begin
            fixed = raw;
        end
        return 10'(fixed);
    endfunction

endpackage

// File: rtl/bt_err_avg.sv
// Phase error averager used while tracking.
// Accumulates 2^AVG_LOG2 signed errors and reports their floor average.
// Optional macro BT_TRACK_DEADBAND_EN adds a deadband input: errors whose
// magnitude is within the deadband are accumulated as zero.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : drop the partial accumulation
//   valid     : err carries a new sample this cycle
//   err       : signed error, us
//   deadband  : (macro only) deadband magnitude, us
//   adj       : floor average, combinational, meaningful with adj_valid
//   adj_valid : this sample completes a block and its average is non-zero
module bt_err_avg
    import bt_clk_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              valid,
    input  logic signed [9:0] err,
`ifdef BT_TRACK_DEADBAND_EN
    input  logic        [4:0] deadband,
`endif
    output logic signed [9:0] adj,
    output logic              adj_valid
);

    localparam int ACC_W = 10 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic signed [ACC_W-1:0] acc_r;
    logic        [CNT_W-1:0] cnt_r;
    logic signed [9:0]       err_eff_s;
    logic signed [ACC_W-1:0] sum_s;
    logic                    done_s;

`ifdef BT_TRACK_DEADBAND_EN
    logic [9:0] mag_s;

    // Small errors inside the deadband are treated as perfect alignment.
    always_comb begin
        mag_s = err[9] ? 10'(-err) : err;
        if (mag_s <= {5'd0, deadband}) begin
            err_eff_s = 10'sd0;
        end else begin
            err_eff_s = err;
        end
    end
`else
    assign err_eff_s = err;
`endif

    // Running sum including the current sample, and its floor average.
    always_comb begin
        sum_s     = acc_r + ACC_W'(err_eff_s);
        adj       = 10'(sum_s >>> AVG_LOG2);
        done_s    = valid && (cnt_r == CNT_LAST);
        adj_valid = done_s && (adj != 10'sd0);
    end

    // Accumulator and sample counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= '0;
            cnt_r <= '0;
        end else if (clear) begin
            acc_r <= '0;
            cnt_r <= '0;
        end else if (done_s) begin
            acc_r <= '0;
            cnt_r <= '0;
        end else if (valid) begin
            acc_r <= sum_s;
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/bt_slave_clk_tracker.sv
// Slave clock tracker: measures correlator sync arrival against the expected
// slot position, issues averaged phase corrections, resizes the uncertainty
// window from sync/miss history and declares loss of sync.
// Optional macro BT_TRACK_DEADBAND_EN adds input regi_deadband.
//   clk_6M, rst           : 6 MHz clock, asynchronous active-high reset
//   enable                : tracking enable, low forces IDLE
//   p_1us                 : 1 us strobe
//   s_counter_1us         : slave intra-slot us counter
//   corre_sync_p          : correlator sync pulse
//   s_conns_uncerWindow   : uncertainty window from the clock block
//   regi_sync_pos         : expected counter value at sync
//   regi_acq_winsize      : window size in ACQUIRE
//   regi_trk_winsize      : nominal window size in TRACK
//   regi_deadband         : (macro only) tracking deadband, us
//   adj_p / adj_us        : correction pulse and signed correction, us
//   s_uncerWinSize        : window size to the clock block
//   locked                : high in TRACK
//   lost_p                : pulse on TRACK -> LOST
//   miss_cnt              : consecutive missed windows
module bt_slave_clk_tracker
    import bt_clk_pkg::*;
#(
    parameter int AVG_LOG2   = 2,
    parameter int MISS_LIMIT = 8,
    parameter int WIN_STEP   = 10
) (
    input  logic       clk_6M,
    input  logic       rst,
    input  logic       enable,
    input  logic       p_1us,
    input  logic [9:0] s_counter_1us,
    input  logic       corre_sync_p,
    input  logic       s_conns_uncerWindow,
    input  logic [9:0] regi_sync_pos,
    input  logic [8:0] regi_acq_winsize,
    input  logic [8:0] regi_trk_winsize,
`ifdef BT_TRACK_DEADBAND_EN
    input  logic [4:0] regi_deadband,
`endif
    output logic       adj_p,
    output logic [9:0] adj_us,
    output logic [8:0] s_uncerWinSize,
    output logic       locked,
    output logic       lost_p,
    output logic [3:0] miss_cnt
);

    localparam logic [9:0] WIN_STEP_W   = 10'(WIN_STEP);
    localparam logic [3:0] MISS_LIMIT_W = 4'(MISS_LIMIT);

    trk_state_e        state_r;
    logic              win_d_r;
    logic              taken_r;
    logic              rise_s;
    logic              fall_s;
    logic              active_s;
    logic              accept_s;
    logic              miss_s;
    logic              run_s;
    logic signed [9:0] err_s;
    logic signed [9:0] avg_adj_s;
    logic              avg_valid_s;
    logic [3:0]        miss_inc_s;
    logic [9:0]        win_sum_s;
    logic [8:0]        win_wide_s;
    logic              unused_s;

    // The error is taken from s_counter_1us directly, so the strobe is not needed.
    assign unused_s = p_1us;

    assign err_s = slot_err(s_counter_1us, regi_sync_pos);

    // Window edge decode and sync/miss qualification. The falling-edge cycle
    // still counts as inside the window so a coincident sync is a hit.
    always_comb begin
        run_s    = enable && (state_r != IDLE);
        rise_s   = s_conns_uncerWindow && !win_d_r;
        fall_s   = !s_conns_uncerWindow && win_d_r;
        active_s = s_conns_uncerWindow || win_d_r;
        accept_s = run_s && corre_sync_p && active_s && (rise_s || !taken_r);
        miss_s   = run_s && fall_s && !taken_r && !accept_s;
    end

    // Saturating miss increment and clamped window widening.
    always_comb begin
        if (miss_cnt == 4'd15) begin
            miss_inc_s = 4'd15;
        end else begin
            miss_inc_s = miss_cnt + 4'd1;
        end
        win_sum_s = {1'b0, s_uncerWinSize} + WIN_STEP_W;
        if (win_sum_s > {1'b0, HALF_SLOT_US}) begin
            win_wide_s = HALF_SLOT_US;
        end else begin
            win_wide_s = win_sum_s[8:0];
        end
    end

    // Window edge history and "sync already used in this window" flag.
    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            win_d_r <= 1'b0;
            taken_r <= 1'b0;
        end else begin
            win_d_r <= s_conns_uncerWindow;
            if (!run_s) begin
                taken_r <= 1'b0;
            end else if (accept_s) begin
                taken_r <= 1'b1;
            end else if (rise_s) begin
                taken_r <= 1'b0;
            end else begin
                taken_r <= taken_r;
            end
        end
    end

    bt_err_avg #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_err_avg (
        .clk       (clk_6M),
        .rst       (rst),
        .clear     (!enable || (state_r != TRACK)),
        .valid     (accept_s && (state_r == TRACK)),
        .err       (err_s),
`ifdef BT_TRACK_DEADBAND_EN
        .deadband  (regi_deadband),
`endif
        .adj       (avg_adj_s),
        .adj_valid (avg_valid_s)
    );

    // Tracker state machine with registered outputs.
    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            adj_p          <= 1'b0;
            adj_us         <= 10'd0;
            s_uncerWinSize <= 9'd0;
            locked         <= 1'b0;
            lost_p         <= 1'b0;
            miss_cnt       <= 4'd0;
        end else if (!enable) begin
            state_r        <= IDLE;
            adj_p          <= 1'b0;
            adj_us         <= 10'd0;
            s_uncerWinSize <= 9'd0;
            locked         <= 1'b0;
            lost_p         <= 1'b0;
            miss_cnt       <= 4'd0;
        end else begin
            adj_p  <= 1'b0;
            lost_p <= 1'b0;
            case (state_r)
                IDLE: begin
                    state_r        <= ACQUIRE;
                    s_uncerWinSize <= regi_acq_winsize;
                    locked         <= 1'b0;
                end
                // First sync after acquisition or loss is applied as-is.
                ACQUIRE, LOST: begin
                    if (accept_s) begin
                        adj_p          <= 1'b1;
                        adj_us         <= err_s;
                        state_r        <= TRACK;
                        locked         <= 1'b1;
                        miss_cnt       <= 4'd0;
                        s_uncerWinSize <= regi_trk_winsize;
                    end else if (miss_s) begin
                        miss_cnt <= miss_inc_s;
                    end else begin
                        miss_cnt <= miss_cnt;
                    end
                end
                TRACK: begin
                    if (accept_s) begin
                        miss_cnt       <= 4'd0;
                        s_uncerWinSize <= regi_trk_winsize;
                        if (avg_valid_s) begin
                            adj_p  <= 1'b1;
                            adj_us <= avg_adj_s;
                        end else begin
                            adj_p <= 1'b0;
                        end
                    end else if (miss_s) begin
                        miss_cnt <= miss_inc_s;
                        if (miss_inc_s >= MISS_LIMIT_W) begin
                            state_r        <= LOST;
                            lost_p         <= 1'b1;
                            locked         <= 1'b0;
                            s_uncerWinSize <= WIN_OPEN_ALWAYS;
                        end else begin
                            s_uncerWinSize <= win_wide_s;
                        end
                    end else begin
                        miss_cnt <= miss_cnt;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bt_slave_clk_tracker.sv
module tb_bt_slave_clk_tracker;

    logic       clk_6M = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       p_1us = 1'b0;
    logic [9:0] s_counter_1us = 10'd0;
    logic       corre_sync_p = 1'b0;
    logic       s_conns_uncerWindow = 1'b0;
    logic [9:0] regi_sync_pos = 10'd68;
    logic [8:0] regi_acq_winsize = 9'd50;
    logic [8:0] regi_trk_winsize = 9'd40;
`ifdef BT_TRACK_DEADBAND_EN
    logic [4:0] regi_deadband = 5'd2;
`endif
    logic       adj_p;
    logic [9:0] adj_us;
    logic [8:0] s_uncerWinSize;
    logic       locked;
    logic       lost_p;
    logic [3:0] miss_cnt;

    bt_slave_clk_tracker dut (
        .clk_6M              (clk_6M),
        .rst                 (rst),
        .enable              (enable),
        .p_1us               (p_1us),
        .s_counter_1us       (s_counter_1us),
        .corre_sync_p        (corre_sync_p),
        .s_conns_uncerWindow (s_conns_uncerWindow),
        .regi_sync_pos       (regi_sync_pos),
        .regi_acq_winsize    (regi_acq_winsize),
        .regi_trk_winsize    (regi_trk_winsize),
`ifdef BT_TRACK_DEADBAND_EN
        .regi_deadband       (regi_deadband),
`endif
        .adj_p               (adj_p),
        .adj_us              (adj_us),
        .s_uncerWinSize      (s_uncerWinSize),
        .locked              (locked),
        .lost_p              (lost_p),
        .miss_cnt            (miss_cnt)
    );

    always #5 clk_6M = ~clk_6M;

    int cyc = 0;
    always @(posedge clk_6M) begin
        cyc   <= cyc + 1;
        p_1us <= (cyc % 6 == 0);
    end

    localparam int K_ADJ  = 1;
    localparam int K_LOST = 2;
    typedef struct {
        int kind;
        int val;
        int when;
    } ev_t;
    ev_t exp_q[$];
    ev_t mon_e;

    int checks = 0;
    int errors = 0;

    // Reference model: mode names follow the specification's states.
    localparam int M_IDLE = 0, M_ACQ = 1, M_TRACK = 2, M_LOST = 3;
    int m_mode = M_IDLE;
    int m_miss = 0;
    int m_win  = 0;
    int m_errs[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ref_err(input int c, input int p);
        int r;
        r = c - p;
        if (r > 312) r = r - 625;
        else if (r < -312) r = r + 625;
        return r;
    endfunction

    function automatic int floor_div(input int s, input int n);
        if (s >= 0) return s / n;
        return -((-s + n - 1) / n);
    endfunction

    task automatic push_ev(input int kind, input int val, input int when);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.when = when;
        exp_q.push_back(e);
    endtask

    task automatic model_sync(input int e, input int when);
        int ed;
        int s;
        if (m_mode == M_ACQ || m_mode == M_LOST) begin
            push_ev(K_ADJ, e, when);
            m_mode = M_TRACK;
            m_miss = 0;
            m_win  = int'(regi_trk_winsize);
            m_errs.delete();
        end else if (m_mode == M_TRACK) begin
            m_miss = 0;
            m_win  = int'(regi_trk_winsize);
            ed = e;
`ifdef BT_TRACK_DEADBAND_EN
            if (e <= int'(regi_deadband) && -e <= int'(regi_deadband)) ed = 0;
`endif
            m_errs.push_back(ed);
            if (m_errs.size() == 4) begin
                s = 0;
                foreach (m_errs[i]) s += m_errs[i];
                m_errs.delete();
                if (floor_div(s, 4) != 0) push_ev(K_ADJ, floor_div(s, 4), when);
            end
        end
    endtask

    task automatic model_miss(input int when);
        if (m_miss < 15) m_miss++;
        if (m_mode == M_TRACK) begin
            if (m_miss >= 8) begin
                m_mode = M_LOST;
                m_win  = 313;
                push_ev(K_LOST, 0, when);
            end else begin
                m_win = (m_win + 10 > 312) ? 312 : m_win + 10;
            end
        end
    endtask

    // Scoreboard monitor: every adj_p / lost_p must match the oldest expectation.
    initial begin : monitor
        forever begin
            @(negedge clk_6M);
            if (!rst && (adj_p || lost_p)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: adj_p=%0b lost_p=%0b adj_us=%0d at cycle %0d, required none",
                             adj_p, lost_p, $signed(adj_us), cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.kind != (adj_p ? K_ADJ : K_LOST) || mon_e.when != cyc ||
                        (adj_p && int'($signed(adj_us)) != mon_e.val)) begin
                        errors++;
                        $display("FAIL scoreboard_event: got kind=%0d adj_us=%0d cycle=%0d, required kind=%0d adj_us=%0d cycle=%0d",
                                 adj_p ? K_ADJ : K_LOST, $signed(adj_us), cyc, mon_e.kind, mon_e.val, mon_e.when);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_6M);
        #1;
    endtask

    task automatic flush_stale();
        int stale;
        stale = 0;
        while (exp_q.size() > 0 && exp_q[0].when < cyc) begin
            void'(exp_q.pop_front());
            stale++;
        end
        check("missed_events", stale, 0);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_locked"}, int'(locked), (m_mode == M_TRACK) ? 1 : 0);
        check({tag, "_miss_cnt"}, int'(miss_cnt), m_miss);
        check({tag, "_win"}, int'(s_uncerWinSize), m_win);
    endtask

    task automatic offer_sync(inout bit taken, input int cval);
        corre_sync_p  = 1'b1;
        s_counter_1us = 10'(cval);
        if (!taken) begin
            model_sync(ref_err(cval, int'(regi_sync_pos)), cyc + 1);
            taken = 1'b1;
        end
    endtask

    // One uncertainty window: rise, optional sync(s), fall (optionally with sync).
    task automatic window(input bit has_sync, input int cval, input bit at_fall,
                          input bit extra, input int cval2);
        bit taken;
        taken = 1'b0;
        step();
        s_conns_uncerWindow = 1'b1;
        step();
        if (has_sync && !at_fall) offer_sync(taken, cval);
        step();
        corre_sync_p = 1'b0;
        if (extra) offer_sync(taken, cval2);
        step();
        corre_sync_p = 1'b0;
        s_conns_uncerWindow = 1'b0;
        if (has_sync && at_fall) offer_sync(taken, cval);
        if (!taken) model_miss(cyc + 1);
        step();
        corre_sync_p = 1'b0;
        step();
        step();
        flush_stale();
        check_state("window");
    endtask

    task automatic en_off();
        enable = 1'b0;
        m_mode = M_IDLE;
        m_win  = 0;
        m_miss = 0;
        m_errs.delete();
        step();
        step();
        check_state("disabled");
    endtask

    task automatic en_on();
        enable = 1'b1;
        m_mode = M_ACQ;
        m_win  = int'(regi_acq_winsize);
        m_miss = 0;
        step();
        step();
        check_state("acquire");
    endtask

    int wrap_c[3] = '{2, 10, 600};
    int wrap_p[3] = '{620, 600, 5};
    int avg_e[20] = '{2, 3, -1, 1,  -1, 0, 0, 0,  1, -1, 0, 0,  2, 2, 2, 2,  0, 0, 0, 0};

    initial begin : stimulus
        step();
        step();
        check("reset_adj_p", int'(adj_p), 0);
        check("reset_adj_us", int'(adj_us), 0);
        check("reset_win", int'(s_uncerWinSize), 0);
        check("reset_locked", int'(locked), 0);
        check("reset_lost_p", int'(lost_p), 0);
        check("reset_miss_cnt", int'(miss_cnt), 0);
        rst = 1'b0;
        step();

        // First sync in ACQUIRE: adj +3, then TRACK.
        en_on();
        regi_sync_pos = 10'd68;
        window(1'b1, 71, 1'b0, 1'b0, 0);
        check("first_sync_locked", int'(locked), 1);
        check("first_sync_win", int'(s_uncerWinSize), int'(regi_trk_winsize));

        // Slot wrap errors, each observed as a fresh acquisition.
        for (int i = 0; i < 3; i++) begin
            en_off();
            en_on();
            regi_sync_pos = 10'(wrap_p[i]);
            window(1'b1, wrap_c[i], 1'b0, 1'b0, 0);
        end

        // Averaging blocks, including the zero-error acquisition.
        en_off();
        en_on();
        regi_sync_pos = 10'd100;
        window(1'b1, 100, 1'b0, 1'b0, 0);
        for (int i = 0; i < 20; i++) window(1'b1, 100 + avg_e[i], 1'b0, 1'b0, 0);

        // Miss, then sync coincident with the falling edge, then a doubled sync.
        window(1'b0, 0, 1'b0, 1'b0, 0);
        window(1'b1, 105, 1'b1, 1'b0, 0);
        window(1'b1, 100, 1'b0, 1'b1, 200);
        window(1'b1, 100, 1'b0, 1'b0, 0);
        window(1'b1, 100, 1'b0, 1'b0, 0);

        // Widening 30..90, loss on the 8th miss, then immediate recovery.
        regi_trk_winsize = 9'd20;
        window(1'b1, 100, 1'b0, 1'b0, 0);
        for (int i = 0; i < 8; i++) window(1'b0, 0, 1'b0, 1'b0, 0);
        check("lost_win", int'(s_uncerWinSize), 313);
        window(1'b1, 90, 1'b0, 1'b0, 0);
        check("recovered_locked", int'(locked), 1);

        // Widening clamps at 312.
        regi_trk_winsize = 9'd290;
        window(1'b1, 100, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) window(1'b0, 0, 1'b0, 1'b0, 0);
        check("clamped_win", int'(s_uncerWinSize), 312);

        // Disable mid-track with a partial average pending.
        window(1'b1, 103, 1'b0, 1'b0, 0);
        en_off();
        en_on();

        // Randomized windows.
        for (int i = 0; i < 120; i++) begin
            int c;
            int c2;
            bit hs;
            c  = int'($urandom_range(624, 0));
            c2 = int'($urandom_range(624, 0));
            regi_sync_pos = 10'($urandom_range(624, 0));
            regi_trk_winsize = 9'($urandom_range(300, 0));
            hs = ((i / 20) % 2 == 0) ? ($urandom_range(9, 0) != 0) : ($urandom_range(9, 0) < 4);
            window(hs, c, ($urandom_range(6, 0) == 0), ($urandom_range(4, 0) == 0), c2);
            if ($urandom_range(29, 0) == 0) begin
                en_off();
                en_on();
            end
        end

        // Reset right after a sync: the pending correction must vanish.
        en_off();
        en_on();
        step();
        s_conns_uncerWindow = 1'b1;
        step();
        corre_sync_p  = 1'b1;
        s_counter_1us = 10'd300;
        @(posedge clk_6M);
        #1;
        rst = 1'b1;
        #1;
        check("midreset_adj_p", int'(adj_p), 0);
        check("midreset_locked", int'(locked), 0);
        check("midreset_win", int'(s_uncerWinSize), 0);
        corre_sync_p = 1'b0;
        s_conns_uncerWindow = 1'b0;
        step();
        rst = 1'b0;
        m_mode = M_ACQ;
        m_win  = int'(regi_acq_winsize);
        m_miss = 0;
        m_errs.delete();
        step();
        step();
        check_state("after_reset");
        regi_sync_pos = 10'd68;
        window(1'b1, 60, 1'b0, 1'b0, 0);

        step();
        step();
        check("pending_expectations", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
